// File: rtl/mem_stage_if.sv
// EX/MEM -> MEM/WB bus of the memory stage: M-stage fields in, stall request and W-stage fields out.
interface mem_stage_if;
   logic        RegWriteM;
   logic        MemtoRegM;
   logic        MemWriteM;
   logic [31:0] ALUOutM;
   logic [31:0] WriteDataM;
   logic [4:0]  WriteRegM;
   logic        StallM;
   logic        RegWriteW;
   logic        MemtoRegW;
   logic [31:0] ReadDataW;
   logic [31:0] ALUOutW;
   logic [4:0]  WriteRegW;

   modport master (
      output RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM,
      input  StallM, RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WriteRegW
   );

   modport slave (
      input  RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM,
      output StallM, RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WriteRegW
   );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory stage: word-addressed data memory, fixed-latency stall FSM and MEM/WB register.
// Optional MEM_ALIGN_CHECK_EN adds a sticky MisalignM flag, store suppression and zeroed misaligned loads.
module mem_stage #(
   parameter int DEPTH_LOG2 = 6,
   parameter int MEM_LAT    = 2
) (
   input  logic       clk,
   input  logic       reset,
`ifdef MEM_ALIGN_CHECK_EN
   output logic       MisalignM,
`endif
   mem_stage_if.slave bus
);

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

   localparam bit       HAS_LAT = (MEM_LAT > 0);
   localparam logic [3:0] LAT_M1 = (MEM_LAT > 0) ? 4'(MEM_LAT - 1) : 4'd0;

   state_t                stateR;
   logic [3:0]            cntR;
   logic                  memOpS;
   logic                  misalignS;
   logic                  completeS;
   logic                  stallS;
   logic                  storeEnS;
   logic [DEPTH_LOG2-1:0] idxS;
   logic [31:0]           memR [0:(1 << DEPTH_LOG2) - 1];

   // Decode the current M-stage op and decide whether this cycle stalls or completes.
   always_comb begin
      memOpS    = bus.MemtoRegM | bus.MemWriteM;
      idxS      = bus.ALUOutM[DEPTH_LOG2+1:2];
`ifdef MEM_ALIGN_CHECK_EN
      misalignS = memOpS && (bus.ALUOutM[1:0] != 2'b00);
`else
      misalignS = 1'b0;
`endif
      stallS    = 1'b0;
      completeS = 1'b0;
      case (stateR)
         S_IDLE: begin
            if (memOpS && HAS_LAT) begin
               stallS = 1'b1;
            end else begin
               completeS = 1'b1;
            end
         end
         S_WAIT: begin
            if (cntR != 4'd0) begin
               stallS = 1'b1;
            end else begin
               completeS = 1'b1;
            end
         end
         default: begin
            stallS    = 1'b0;
            completeS = 1'b0;
         end
      endcase
      // Reset aborts an in-flight store even on its completion cycle.
      storeEnS = completeS && bus.MemWriteM && !misalignS && !reset;
   end

   assign bus.StallM = stallS;

   // Latency FSM and MEM/WB register; stall cycles insert a bubble and hold the data fields.
   always_ff @(posedge clk) begin
      if (reset) begin
         stateR        <= S_IDLE;
         cntR          <= 4'd0;
         bus.RegWriteW <= 1'b0;
         bus.MemtoRegW <= 1'b0;
         bus.ReadDataW <= 32'd0;
         bus.ALUOutW   <= 32'd0;
         bus.WriteRegW <= 5'd0;
`ifdef MEM_ALIGN_CHECK_EN
         MisalignM     <= 1'b0;
`endif
      end else begin
         case (stateR)
            S_IDLE: begin
               if (memOpS && HAS_LAT) begin
                  stateR <= S_WAIT;
                  cntR   <= LAT_M1;
               end
            end
            S_WAIT: begin
               if (cntR != 4'd0) begin
                  cntR <= cntR - 4'd1;
               end else begin
                  stateR <= S_IDLE;
               end
            end
            default: begin
               stateR <= S_IDLE;
               cntR   <= 4'd0;
            end
         endcase

         if (completeS) begin
            bus.RegWriteW <= bus.RegWriteM;
            bus.MemtoRegW <= bus.MemtoRegM;
            bus.ALUOutW   <= bus.ALUOutM;
            bus.WriteRegW <= bus.WriteRegM;
            if (bus.MemtoRegM) begin
               bus.ReadDataW <= misalignS ? 32'd0 : memR[idxS];
            end
         end else begin
            bus.RegWriteW <= 1'b0;
            bus.MemtoRegW <= 1'b0;
         end

`ifdef MEM_ALIGN_CHECK_EN
         if (misalignS) begin
            MisalignM <= 1'b1;
         end
`endif
      end
   end

   // Data memory write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (storeEnS) begin
         memR[idxS] <= bus.WriteDataM;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: one instance with MEM_LAT=0 and one with MEM_LAT=2,
// a directed vector table, reset/misalignment sequences and random ops against a word-array model.
module tb_mem_stage;
   localparam int DL2   = 6;
   localparam int LAT_A = 0;
   localparam int LAT_B = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_stage_if ifA ();
   mem_stage_if ifB ();

`ifdef MEM_ALIGN_CHECK_EN
   logic misA, misB;
`endif

   mem_stage #(.DEPTH_LOG2(DL2), .MEM_LAT(LAT_A)) dutA (
      .clk(clk), .reset(reset),
`ifdef MEM_ALIGN_CHECK_EN
      .MisalignM(misA),
`endif
      .bus(ifA)
   );

   mem_stage #(.DEPTH_LOG2(DL2), .MEM_LAT(LAT_B)) dutB (
      .clk(clk), .reset(reset),
`ifdef MEM_ALIGN_CHECK_EN
      .MisalignM(misB),
`endif
      .bus(ifB)
   );

   typedef struct {
      int          sel;     // 0 -> dutA (no latency), 1 -> dutB (MEM_LAT=2)
      logic        rw;
      logic        m2r;
      logic        mw;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  wreg;
      logic        chkRd;
      logic [31:0] expRd;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] refMem [2][64];
   logic [31:0] refRd  [2];
   bit          refMis [2];
   vec_t        tbl    [12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %h required %h", nm, act, exp);
      end
   endtask

   task automatic setBus(input int s, input logic rw, input logic m2r, input logic mw,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] wr);
      if (s == 1) begin
         ifB.RegWriteM = rw; ifB.MemtoRegM = m2r; ifB.MemWriteM = mw;
         ifB.ALUOutM = addr; ifB.WriteDataM = wd; ifB.WriteRegM = wr;
      end else begin
         ifA.RegWriteM = rw; ifA.MemtoRegM = m2r; ifA.MemWriteM = mw;
         ifA.ALUOutM = addr; ifA.WriteDataM = wd; ifA.WriteRegM = wr;
      end
   endtask

   task automatic getW(input int s, output logic st, output logic rw, output logic m2r,
                       output logic [31:0] rd, output logic [31:0] alu, output logic [4:0] wr);
      if (s == 1) begin
         st = ifB.StallM; rw = ifB.RegWriteW; m2r = ifB.MemtoRegW;
         rd = ifB.ReadDataW; alu = ifB.ALUOutW; wr = ifB.WriteRegW;
      end else begin
         st = ifA.StallM; rw = ifA.RegWriteW; m2r = ifA.MemtoRegW;
         rd = ifA.ReadDataW; alu = ifA.ALUOutW; wr = ifA.WriteRegW;
      end
   endtask

   task automatic chkZeroW(input int s, input string nm);
      logic st, rw, m2r; logic [31:0] rd, alu; logic [4:0] wr;
      getW(s, st, rw, m2r, rd, alu, wr);
      chk({nm, " RegWriteW"}, {31'd0, rw}, 32'd0);
      chk({nm, " MemtoRegW"}, {31'd0, m2r}, 32'd0);
      chk({nm, " ReadDataW"}, rd, 32'd0);
      chk({nm, " ALUOutW"}, alu, 32'd0);
      chk({nm, " WriteRegW"}, {27'd0, wr}, 32'd0);
   endtask

   // Present one op, follow it through its stall cycles, then compare W against the model.
   task automatic runOp(input vec_t v, input string nm, output logic [31:0] rdOut);
      logic st, rw, m2r; logic [31:0] rd, alu; logic [4:0] wr;
      int stalls, lat, idx;
      bit done, memop, mis;
      lat   = (v.sel == 1) ? LAT_B : LAT_A;
      memop = v.m2r | v.mw;
      @(negedge clk);
      setBus(v.sel, v.rw, v.m2r, v.mw, v.addr, v.wdata, v.wreg);
      setBus(1 - v.sel, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      stalls = 0;
      done   = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         #1;
         getW(v.sel, st, rw, m2r, rd, alu, wr);
         @(posedge clk);
         #1;
         if (st) begin
            stalls++;
            getW(v.sel, st, rw, m2r, rd, alu, wr);
            chk({nm, " bubble RegWriteW"}, {31'd0, rw}, 32'd0);
            chk({nm, " bubble MemtoRegW"}, {31'd0, m2r}, 32'd0);
            @(negedge clk);
         end else begin
            done = 1'b1;
         end
      end
      rdOut = 32'd0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: StallM still high after 20 cycles, required low", nm);
      end else begin
         chk({nm, " stall cycles"}, stalls, memop ? lat : 0);
         idx = int'(v.addr[7:2]);
`ifdef MEM_ALIGN_CHECK_EN
         mis = memop && (v.addr[1:0] != 2'b00);
`else
         mis = 1'b0;
`endif
         if (v.m2r) refRd[v.sel] = mis ? 32'd0 : refMem[v.sel][idx];
         if (v.mw && !mis) refMem[v.sel][idx] = v.wdata;
         if (mis) refMis[v.sel] = 1'b1;
         getW(v.sel, st, rw, m2r, rd, alu, wr);
         chk({nm, " RegWriteW"}, {31'd0, rw}, {31'd0, v.rw});
         chk({nm, " MemtoRegW"}, {31'd0, m2r}, {31'd0, v.m2r});
         chk({nm, " ALUOutW"}, alu, v.addr);
         chk({nm, " WriteRegW"}, {27'd0, wr}, {27'd0, v.wreg});
         chk({nm, " ReadDataW"}, rd, refRd[v.sel]);
`ifdef MEM_ALIGN_CHECK_EN
         chk({nm, " MisalignM"}, {31'd0, (v.sel == 1) ? misB : misA}, {31'd0, refMis[v.sel]});
`endif
         rdOut = rd;
      end
   endtask

   function automatic vec_t mk(input int s, input logic rw, input logic m2r, input logic mw,
                               input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
      vec_t v;
      v.sel = s; v.rw = rw; v.m2r = m2r; v.mw = mw;
      v.addr = a; v.wdata = d; v.wreg = r; v.chkRd = 1'b0; v.expRd = 32'd0;
      return v;
   endfunction

   initial begin
      logic [31:0] rd;
      logic        st0, st1;
      vec_t        v;

      tbl[0]  = mk(1, 1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 5'd5);
      tbl[1]  = mk(1, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0);
      tbl[2]  = mk(1, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 5'd8);
      tbl[2].chkRd = 1'b1; tbl[2].expRd = 32'hDEAD_BEEF;
      tbl[3]  = mk(0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_00A0, 5'd0);
      tbl[4]  = mk(0, 1'b0, 1'b0, 1'b1, 32'h0000_0004, 32'h0000_00B4, 5'd0);
      tbl[5]  = mk(0, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd3);
      tbl[5].chkRd = 1'b1; tbl[5].expRd = 32'h0000_00A0;
      tbl[6]  = mk(0, 1'b1, 1'b1, 1'b0, 32'h0000_0004, 32'h0, 5'd4);
      tbl[6].chkRd = 1'b1; tbl[6].expRd = 32'h0000_00B4;
      tbl[7]  = mk(0, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_00C0, 5'd0);
      tbl[8]  = mk(0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0, 5'd9);
      tbl[8].chkRd = 1'b1; tbl[8].expRd = 32'h0000_00C0;
      tbl[9]  = mk(1, 1'b0, 1'b0, 1'b1, 32'h0000_0020, 32'h0000_0001, 5'd0);
      tbl[10] = mk(1, 1'b1, 1'b1, 1'b1, 32'h0000_0020, 32'h0000_0002, 5'd6);
      tbl[10].chkRd = 1'b1; tbl[10].expRd = 32'h0000_0001;
      tbl[11] = mk(1, 1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 5'd7);
      tbl[11].chkRd = 1'b1; tbl[11].expRd = 32'h0000_0002;

      // Reset state
      reset = 1'b1;
      setBus(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      setBus(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      repeat (3) @(posedge clk);
      #1;
      chkZeroW(0, "reset A");
      chkZeroW(1, "reset B");
      chk("reset StallM A", {31'd0, ifA.StallM}, 32'd0);
      chk("reset StallM B", {31'd0, ifB.StallM}, 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
      chk("reset MisalignM B", {31'd0, misB}, 32'd0);
`endif
      @(negedge clk);
      reset = 1'b0;
      for (int s = 0; s < 2; s++) begin
         refRd[s]  = 32'd0;
         refMis[s] = 1'b0;
      end

      // Preload both memories with zeros so the model starts from known contents
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 64; i++) begin
            refMem[s][i] = 32'd0;
            runOp(mk(s, 1'b0, 1'b0, 1'b1, 32'(i * 4), 32'd0, 5'd0), "preload", rd);
         end
      end

      for (int i = 0; i < 12; i++) begin
         runOp(tbl[i], $sformatf("tbl%0d", i), rd);
         if (tbl[i].chkRd) chk($sformatf("tbl%0d expected ReadDataW", i), rd, tbl[i].expRd);
      end

      // Reset in the first WAIT cycle aborts a store of 0x55 to 0x8
      @(negedge clk);
      setBus(1, 1'b1, 1'b0, 1'b1, 32'h0000_0008, 32'h0000_0055, 5'd2);
      setBus(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      @(posedge clk);
      #1;
      chk("abort WAIT StallM", {31'd0, ifB.StallM}, 32'd1);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chkZeroW(1, "abort reset B");
      @(negedge clk);
      reset = 1'b0;
      setBus(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      for (int s = 0; s < 2; s++) begin
         refRd[s]  = 32'd0;
         refMis[s] = 1'b0;
      end
      #1;
      st0 = ifA.StallM;
      st1 = ifB.StallM;
      chk("post-reset StallM A", {31'd0, st0}, 32'd0);
      chk("post-reset StallM B", {31'd0, st1}, 32'd0);
      runOp(mk(1, 1'b1, 1'b1, 1'b0, 32'h0000_0008, 32'd0, 5'd2), "abort load", rd);
      chk("abort load old data", rd, 32'd0);

`ifdef MEM_ALIGN_CHECK_EN
      // Misaligned store is dropped; the flag sticks across later aligned traffic
      runOp(mk(1, 1'b0, 1'b0, 1'b1, 32'h0000_0006, 32'h0000_0077, 5'd0), "mis store", rd);
      chk("mis flag set", {31'd0, misB}, 32'd1);
      runOp(mk(1, 1'b1, 1'b1, 1'b0, 32'h0000_0004, 32'd0, 5'd1), "mis check word", rd);
      chk("mis store suppressed", rd, 32'd0);
      runOp(mk(1, 1'b0, 1'b0, 1'b1, 32'h0000_000C, 32'h0000_0099, 5'd0), "mis aligned st", rd);
      runOp(mk(1, 1'b1, 1'b1, 1'b0, 32'h0000_000C, 32'd0, 5'd1), "mis aligned ld", rd);
      chk("mis aligned data", rd, 32'h0000_0099);
      chk("mis flag sticky", {31'd0, misB}, 32'd1);
`endif

      // Random traffic on both instances against the word-array model
      for (int n = 0; n < 200; n++) begin
         int kind;
         kind    = $urandom_range(0, 3);
         v       = mk($urandom_range(0, 1), 1'($urandom), 1'b0, 1'b0, $urandom, $urandom,
                      5'($urandom));
         v.m2r   = (kind == 1) || (kind == 3);
         v.mw    = (kind == 2) || (kind == 3);
         runOp(v, $sformatf("rand%0d", n), rd);
      end

      @(negedge clk);
      setBus(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      setBus(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
